// File: rtl/cpp_program_loader_pkg.sv
// Shared definitions for the program loader and the processor model it drives:
// FSM encodings, register-bus geometry and a register-slice helper.
package cpp_program_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_RUN  = 3'd2;
  localparam state_t ST_SNAP = 3'd3;
  localparam state_t ST_DUMP = 3'd4;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int REGBUS_W = 1024;

  // Register 0 sits in the most significant word of the flat bus.
  function automatic logic [XLEN-1:0] reg_slice(input logic [REGBUS_W-1:0] rb,
                                                input logic [4:0] i);
    return rb[(REGBUS_W-1) - int'(i)*XLEN -: XLEN];
  endfunction

endpackage

// File: rtl/cpp_program_loader_if.sv
// Host-side streams of the program loader: program fill in, register dump out.
interface cpp_program_loader_if;
  import cpp_program_loader_pkg::*;

  logic            wr_valid;
  logic            wr_ready;
  logic [XLEN-1:0] wr_data;
  logic            dump_valid;
  logic            dump_ready;
  logic [XLEN-1:0] dump_data;
  logic [4:0]      dump_idx;
  logic            dump_last;

  modport master (
    output wr_valid, wr_data, dump_ready,
    input  wr_ready, dump_valid, dump_data, dump_idx, dump_last
  );

  modport slave (
    input  wr_valid, wr_data, dump_ready,
    output wr_ready, dump_valid, dump_data, dump_idx, dump_last
  );
endinterface

// File: rtl/cpp_program_loader_prog_mem.sv
// Program buffer: DEPTH x 32 words, synchronous write, combinational read.
module cpp_prog_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cpp_program_loader.sv
// Replays a buffered program into the processor load port, free-runs it for a
// programmed number of cycles, then snapshots and streams out the registers.
module cpp_program_loader
  import cpp_program_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  cpp_program_loader_if.slave bus,
  input  logic                start,
  input  logic [31:0]         run_cycles,
  output logic                busy,
  output logic                done,
  output logic [31:0]         inst,
  output logic [31:0]         instAddr,
  output logic                load,
  input  logic [REGBUS_W-1:0] regOut
);
  localparam int unsigned AW = $clog2(DEPTH);

  state_t              state;
  logic [AW:0]         count;
  logic [AW:0]         count_nxt;
  logic [AW-1:0]       ld_idx;
  logic [AW-1:0]       rd_addr;
  logic [31:0]         rem;
  logic [4:0]          idx;
  logic [REGBUS_W-1:0] snapshot;
  logic [31:0]         rd_data;
  logic [31:0]         first_word;
  logic                wr_fire;
  logic                mem_we;
  logic                dump_fire;

  assign bus.wr_ready = (state == ST_IDLE) && (count < (AW+1)'(DEPTH));
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign mem_we       = wr_fire && !clr;
  assign count_nxt    = clr ? '0 : count + (AW+1)'(mem_we);

  // The read port looks one word ahead during LOAD so inst stays registered;
  // a word written in the same cycle as start bypasses the buffer.
  assign rd_addr    = (state == ST_LOAD) ? ld_idx + AW'(1) : '0;
  assign first_word = (mem_we && count == '0) ? bus.wr_data : rd_data;

  assign busy           = (state != ST_IDLE);
  assign dump_fire      = bus.dump_valid && bus.dump_ready;
  assign bus.dump_valid = (state == ST_DUMP);
  assign bus.dump_data  = reg_slice(snapshot, idx);
  assign bus.dump_idx   = idx;
  assign bus.dump_last  = (state == ST_DUMP) && (idx == 5'(NUM_REGS-1));

  cpp_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      ld_idx   <= '0;
      rem      <= '0;
      idx      <= '0;
      snapshot <= '0;
      load     <= 1'b0;
      inst     <= '0;
      instAddr <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          count <= count_nxt;
          if (start) begin
            rem    <= run_cycles;
            ld_idx <= '0;
            if (count_nxt != '0) begin
              state    <= ST_LOAD;
              load     <= 1'b1;
              inst     <= first_word;
              instAddr <= BASE_ADDR;
            end else if (run_cycles != '0) begin
              state <= ST_RUN;
            end else begin
              state <= ST_SNAP;
            end
          end
        end
        ST_LOAD: begin
          if ({1'b0, ld_idx} + (AW+1)'(1) < count) begin
            ld_idx   <= ld_idx + AW'(1);
            inst     <= rd_data;
            instAddr <= instAddr + ADDR_STEP;
          end else begin
            load  <= 1'b0;
            state <= (rem == '0) ? ST_SNAP : ST_RUN;
          end
        end
        ST_RUN: begin
          rem <= rem - 32'd1;
          if (rem == 32'd1) state <= ST_SNAP;
        end
        ST_SNAP: begin
          snapshot <= regOut;
          idx      <= '0;
          state    <= ST_DUMP;
        end
        ST_DUMP: begin
          if (dump_fire) begin
            if (idx == 5'(NUM_REGS-1)) begin
              idx   <= '0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpp_program_loader.sv
// Scoreboard bench for cpp_program_loader: a time-stamped register model stands
// in for the processor; expected load beats, dump words and busy lengths are queued.
module tb_cpp_program_loader;
  import cpp_program_loader_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] STEP  = 32'd4;

  typedef struct {
    int unsigned c;
    logic [31:0] inst;
    logic [31:0] addr;
  } load_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } dump_exp_t;

  logic                clk;
  logic                rst;
  logic                clr;
  logic                start;
  logic [31:0]         run_cycles;
  logic                busy;
  logic                done;
  logic [31:0]         inst;
  logic [31:0]         instAddr;
  logic                load;
  logic [REGBUS_W-1:0] regOut;
  int unsigned         cyc = 0;

  cpp_program_loader_if bus ();

  cpp_program_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .ADDR_STEP (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (bus),
    .start      (start),
    .run_cycles (run_cycles),
    .busy       (busy),
    .done       (done),
    .inst       (inst),
    .instAddr   (instAddr),
    .load       (load),
    .regOut     (regOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor stand-in: every register value is a function of the clock count.
  function automatic logic [31:0] proc_reg(input int unsigned c, input int unsigned r);
    return (32'(c) * 32'h9E37_79B1) ^ (32'(r) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always_comb begin
    regOut = '0;
    for (int r = 0; r < 32; r++) regOut[1023 - 32*r -: 32] = proc_reg(cyc, r);
  end

  load_exp_t   load_q [$];
  dump_exp_t   dump_q [$];
  int unsigned busy_q [$];
  logic [31:0] prog   [$];
  int          tests = 0;
  int          fails = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a load beat, a dump transfer or done.
  initial begin
    logic        prev_stall, prev_done, prev_last_fire;
    logic [31:0] prev_data;
    logic [4:0]  prev_idx;
    int unsigned busy_cnt, stall_cnt;
    load_exp_t   le;
    dump_exp_t   de;
    prev_stall = 0; prev_done = 0; prev_last_fire = 0;
    prev_data = '0; prev_idx = '0; busy_cnt = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; stall_cnt = 0;
        prev_stall = 0; prev_done = 0; prev_last_fire = 0;
      end else begin
        if (load) begin
          if (load_q.size() == 0) check("unexpected_load", 32'(load), 32'd0);
          else begin
            le = load_q.pop_front();
            check("load_cycle", cyc, le.c);
            check("load_inst", inst, le.inst);
            check("load_addr", instAddr, le.addr);
          end
        end
        if (prev_stall) begin
          check("stall_data", bus.dump_data, prev_data);
          check("stall_idx", 32'(bus.dump_idx), 32'(prev_idx));
        end
        if (bus.dump_valid && bus.dump_ready) begin
          if (dump_q.size() == 0) check("unexpected_dump", 32'(bus.dump_valid), 32'd0);
          else begin
            de = dump_q.pop_front();
            check("dump_data", bus.dump_data, de.data);
            check("dump_idx", 32'(bus.dump_idx), 32'(de.idx));
            check("dump_last", 32'(bus.dump_last), 32'(de.last));
          end
        end
        if (done) begin
          check("done_busy", 32'(busy), 32'd0);
          check("done_after_last", 32'(prev_last_fire), 32'd1);
          check("done_single", 32'(prev_done), 32'd0);
          if (busy_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
          else check("busy_cycles", busy_cnt, busy_q.pop_front() + stall_cnt);
          busy_cnt = 0; stall_cnt = 0;
        end
        if (busy) busy_cnt++;
        if (bus.dump_valid && !bus.dump_ready) stall_cnt++;
        prev_stall     = bus.dump_valid && !bus.dump_ready;
        prev_data      = bus.dump_data;
        prev_idx       = bus.dump_idx;
        prev_last_fire = bus.dump_valid && bus.dump_ready && bus.dump_last;
        prev_done      = done;
      end
    end
  end

  task automatic flush_model();
    load_q.delete(); dump_q.delete(); busy_q.delete(); prog.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fill_word(input logic [31:0] w);
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    check("wr_ready", 32'(bus.wr_ready), 32'(prog.size() < DEPTH));
    if (prog.size() < DEPTH) prog.push_back(w);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_clr(input bit with_wr);
    clr = 1'b1;
    if (with_wr) begin bus.wr_valid = 1'b1; bus.wr_data = $urandom; end
    @(posedge clk); #1;
    clr = 1'b0; bus.wr_valid = 1'b0;
    prog.delete();
    check("clr_wr_ready", 32'(bus.wr_ready), 32'd1);
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = ready pattern 1,0,0,1
  task automatic run(input logic [31:0] rc, input int mode, input bit noise,
                     input bit with_wr, input logic [31:0] wword);
    int unsigned c0, sc, n;
    bit got;
    if (with_wr) begin
      bus.wr_valid = 1'b1; bus.wr_data = wword;
      if (prog.size() < DEPTH) prog.push_back(wword);
    end
    start = 1'b1; run_cycles = rc; c0 = cyc;
    n  = prog.size();
    sc = c0 + n + rc + 1;
    for (int i = 0; i < int'(n); i++)
      load_q.push_back('{c: c0 + 1 + i, inst: prog[i], addr: BASE + 32'(i) * STEP});
    for (int r = 0; r < 32; r++)
      dump_q.push_back('{data: proc_reg(sc, r), idx: 5'(r), last: (r == 31)});
    busy_q.push_back(n + rc + 33);
    @(posedge clk); #1;
    start = 1'b0; bus.wr_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done) got = 1;
      else begin
        case (mode)
          1:       bus.dump_ready = 1'($urandom_range(0, 1));
          2:       bus.dump_ready = (k % 4 == 0) || (k % 4 == 3);
          default: bus.dump_ready = 1'b1;
        endcase
        if (noise && busy) begin
          start        = 1'($urandom_range(0, 1));
          clr          = 1'($urandom_range(0, 1));
          bus.wr_valid = 1'($urandom_range(0, 1));
          bus.wr_data  = $urandom;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0; clr = 1'b0; bus.wr_valid = 1'b0; bus.dump_ready = 1'b1;
    if (!got) begin
      tests++; fails++;
      $display("FAIL run_timeout: done not seen, busy=%0b required done within 3000 cycles", busy);
      pulse_reset();
      flush_model();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tp [3];
    int unsigned c0;
    tp[0] = 32'h2008_0005; tp[1] = 32'h2009_0007; tp[2] = 32'h0109_5020;
    rst = 1'b1; clr = 1'b0; start = 1'b0; run_cycles = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.dump_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_load", 32'(load), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_instAddr", instAddr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_dump_data", bus.dump_data, 32'd0);
    check("rst_dump_idx", 32'(bus.dump_idx), 32'd0);
    check("rst_dump_last", 32'(bus.dump_last), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Reference program, then the same program with a 1,0,0,1 stall pattern.
    for (int i = 0; i < 3; i++) fill_word(tp[i]);
    run(32'd3, 0, 0, 0, '0);
    run(32'($urandom_range(1, 20)), 2, 0, 0, '0);

    // Empty buffer: straight to SNAP, and straight to RUN.
    do_clr(0);
    run(32'd0, 0, 0, 0, '0);
    run(32'd5, 1, 0, 0, '0);

    // Random programs with ignored start/clr/wr_valid noise while busy.
    for (int it = 0; it < 4; it++) begin
      if ($urandom_range(0, 1) == 1) do_clr(0);
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) fill_word($urandom);
      run(32'($urandom_range(0, 20)), 1, 1, 0, '0);
      run(32'($urandom_range(0, 20)), 1, 0, 0, '0);
    end

    // Start with a same-cycle write, from empty and from a non-empty buffer.
    do_clr(0);
    run(32'd2, 0, 0, 1, $urandom);
    run(32'd1, 1, 0, 1, $urandom);

    // clr wins over a same-cycle write: the next run must load nothing.
    do_clr(1);
    run(32'd1, 0, 0, 0, '0);

    // Fill to capacity; further writes refused; then run the full buffer.
    for (int i = 0; i < int'(DEPTH) + 4; i++) fill_word($urandom);
    run(32'd2, 1, 0, 0, '0);
    do_clr(0);

    // Reset while the second of three words is on the load port.
    for (int i = 0; i < 3; i++) fill_word($urandom);
    start = 1'b1; run_cycles = 32'd5; c0 = cyc;
    for (int i = 0; i < 3; i++)
      load_q.push_back('{c: c0 + 1 + i, inst: prog[i], addr: BASE + 32'(i) * STEP});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_inst", inst, 32'd0);
    check("midrst_instAddr", instAddr, 32'd0);
    check("midrst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("midrst_dump_data", bus.dump_data, 32'd0);
    flush_model();
    for (int i = 0; i < 2; i++) fill_word($urandom);
    run(32'd4, 0, 0, 0, '0);

    repeat (3) @(posedge clk);
    #1;
    check("load_q_drained", load_q.size(), 32'd0);
    check("dump_q_drained", dump_q.size(), 32'd0);
    check("busy_q_drained", busy_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpp_program_loader.md
# cpp_program_loader

Stimulus-side companion to the C++-backed processor model: accepts a program as a 32-bit word stream, replays it into the processor's load port (`inst`, `instAddr`, `load`), lets the processor free-run for a programmed number of cycles, then snapshots the processor's flat 1024-bit register bus and streams the 32 registers back out one word per handshake. It sits between the testbench/host side and the processor's load/readout interface, so runs can be driven and observed without per-cycle PLI stimulus.

## Interface
- `DEPTH`, 256: program buffer depth in 32-bit words (power of two, ≥2).
- `BASE_ADDR`, 32'h0000_0000: `instAddr` of program word 0.
- `ADDR_STEP`, 4: `instAddr` increment per word.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous clear of the program buffer count; honoured only in IDLE.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in 32: program fill stream; transfer on `wr_valid && wr_ready`.
- `start` in 1: single-cycle request to begin LOAD; sampled only in IDLE.
- `run_cycles` in 32: free-run cycle count, captured on the accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on the last dump transfer.
- `inst` out 32, `instAddr` out 32, `load` out 1: drive the processor's matching inputs; all registered.
- `regOut` in 1024: processor register bus; register 0 occupies [1023:992], register 31 occupies [31:0].
- `dump_valid` out 1 / `dump_ready` in 1 / `dump_data` out 32 / `dump_idx` out 5 / `dump_last` out 1: register readout stream.

## Operation
- States: IDLE → LOAD → RUN → SNAP → DUMP → IDLE.
- IDLE: `wr_ready = (count < DEPTH)`. Each accepted word goes to `mem[count]`, then `count` increments. `clr` zeroes `count`; `clr` takes priority over a same-cycle write. `start` leaves IDLE: to LOAD if `count != 0`, else to RUN. `start` and `wr` in the same cycle: the write is accepted and included in `count`.
- LOAD: exactly `count` cycles. In cycle i: `load=1`, `inst=mem[i]`, `instAddr = BASE_ADDR + i*ADDR_STEP` (mod 2^32). Then go to RUN.
- RUN: `load=0` for exactly `run_cycles` cycles, so the processor clocks that many times. If `run_cycles == 0`, go directly to SNAP.
- SNAP: one cycle. At its closing edge, latch `regOut` into the snapshot register. The latched value reflects exactly `run_cycles` processor clocks after the last load. Then go to DUMP.
- DUMP: present `dump_data = snapshot[idx]`, `dump_idx = idx`, and `dump_last = (idx == 31)`. Advance on `dump_valid && dump_ready`. After the transfer at idx 31, pulse `done` and return to IDLE.
- `load = 0` in every state except LOAD; the processor free-runs whenever the loader is not loading, which is inherent to the processor.
- `start`, `clr` and `wr_valid` are ignored while `busy`. The program buffer persists across runs until `clr`.
- `rst` at any time, including mid-LOAD or mid-DUMP, forces IDLE on the next edge:
  - `count=0`, `idx=0`, snapshot cleared.
  - Outputs: `load=0`, `inst=0`, `instAddr=0`, `busy=0`, `done=0`, `dump_valid=0`, `dump_data=0`, `dump_last=0`, `dump_idx=0`.
  - `wr_ready=1`.

## Timing
- `start` accepted at edge T puts LOAD word 0 on the outputs in cycle T+1; the processor consumes it at edge T+2.
- Total busy cycles = `count + run_cycles + 1 + 32 + dump stall cycles`.
- `dump_valid` rises the cycle after SNAP and stays high until the idx-31 transfer.
- `dump_data` and `dump_idx` are held stable while `dump_valid && !dump_ready`.
- `done` is high in the cycle after the final transfer, coincident with `busy=0`.
- Back-to-back runs: `start` may be asserted in that same first IDLE cycle.
- Run counter: 32 bits. `run_cycles = 32'hFFFF_FFFF` is legal and must not wrap early.

## Structure
- Shared include `cpp_defs.vh`:
  - state encodings (IDLE=0, LOAD=1, RUN=2, SNAP=3, DUMP=4);
  - `NUM_REGS=32`, `XLEN=32`, `REGBUS_W=1024`.
  - The processor module and this block both use it.
- Sub-module `cpp_prog_mem`: DEPTH×32 buffer with synchronous write and combinational read, indexed by the write pointer or the LOAD index.
- Top level holds the FSM, counters, snapshot register and dump mux.

## Test plan
- Fill 3 words (`0x2008_0005`, `0x2009_0007`, `0x0109_5020`), then `start` with `run_cycles=3` → `load` high for exactly 3 cycles with `instAddr` 0, 4, 8; then 3 cycles of `load=0`; then 32 dump words with `dump_idx` 0..31, `dump_last` only at 31, and `done` one cycle later.
- Dump with `dump_ready` toggling 1,0,0,1 → no words lost or duplicated; `dump_data` stable during stalls.
- `count=0`, `run_cycles=0` → no `load` cycle, SNAP immediately, 32-word dump of the current processor state.
- Write 256 words → `wr_ready` drops after the 256th; a 257th `wr_valid` is not accepted. `clr` in IDLE → `wr_ready=1`, `count=0`.
- Assert `rst` at LOAD word 1 of 3 → next cycle `load=0`, `busy=0`, `count=0`; a subsequent fill + `start` runs normally.
- `start` pulsed again mid-RUN, and `wr_valid` during DUMP → both ignored; LOAD length and dump contents are unchanged.
